// File: rtl/axis_elem_packer.sv
// axis_elem_packer
//   Packs PE consecutive ELEM_WIDTH-bit AXI-Stream elements into one
//   PE*ELEM_WIDTH-bit output word. Element 0 of a word lands in the LSBs.
//   The output is a single registered word. Sustained throughput is
//   1 element/cycle.
//
// Optional feature (macro PACKER_TLAST_EN):
//   When defined, words are grouped into blocks of BDIM words, and
//   m_axis_output_tlast marks the last word of each block.
//   When undefined, the tlast port and the word counter do not exist.
//
// Ports:
//   ap_clk, ap_rst_n      clock; asynchronous active-low reset
//   s_axis_input_*        element input (tdata/tvalid/tready)
//   m_axis_output_*       packed word output (tdata/tvalid/tready[/tlast])
module axis_elem_packer #(
  parameter int ELEM_WIDTH = 8,
  parameter int PE         = 4,
  parameter int BDIM       = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [ELEM_WIDTH-1:0]    s_axis_input_tdata,
  input  logic                     s_axis_input_tvalid,
  output logic                     s_axis_input_tready,
  output logic [PE*ELEM_WIDTH-1:0] m_axis_output_tdata,
  output logic                     m_axis_output_tvalid,
  input  logic                     m_axis_output_tready
`ifdef PACKER_TLAST_EN
  ,
  output logic                     m_axis_output_tlast
`endif
);

  localparam int ECW = $clog2(PE);
  localparam logic [ECW-1:0] LAST_SLOT = ECW'(PE - 1);

  logic [ECW-1:0]                  r_elem_cnt;
  // Slot PE-1 is never stored: the final element goes straight into the
  // output register together with the held slots.
  logic [PE-2:0][ELEM_WIDTH-1:0]   r_asm;
  logic [PE*ELEM_WIDTH-1:0]        r_out_data;
  logic                            r_out_vld;

  logic w_last_slot, w_in_xfer, w_out_xfer, w_complete;

  assign w_last_slot = (r_elem_cnt == LAST_SLOT);
  assign w_out_xfer  = r_out_vld & m_axis_output_tready;
  // Stall only when the word about to complete has nowhere to go.
  // Gated with reset so tready is low while reset is held.
  assign s_axis_input_tready = ap_rst_n &
                               ~(w_last_slot & r_out_vld & ~m_axis_output_tready);
  assign w_in_xfer  = s_axis_input_tvalid & s_axis_input_tready;
  assign w_complete = w_in_xfer & w_last_slot;

  assign m_axis_output_tdata  = r_out_data;
  assign m_axis_output_tvalid = r_out_vld;

  // Assembly slots, one register per element position.
  for (genvar g = 0; g < PE - 1; g++) begin : g_slot
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
        r_asm[g] <= '0;
      else if (w_in_xfer && r_elem_cnt == ECW'(g))
        r_asm[g] <= s_axis_input_tdata;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      r_elem_cnt <= '0;
    else if (w_in_xfer)
      r_elem_cnt <= w_last_slot ? '0 : r_elem_cnt + 1'b1;
  end

  // A completing word may only arrive when the output register is empty or
  // draining this cycle (tready logic above), so loading always wins.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else if (w_complete) begin
      r_out_data <= {s_axis_input_tdata, r_asm};
      r_out_vld  <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_vld  <= 1'b0;
    end
  end

`ifdef PACKER_TLAST_EN
  localparam int WCW = (BDIM > 1) ? $clog2(BDIM) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(BDIM - 1);

  // Index of the word currently held in (or next loaded into) the output
  // register; advances only when a word leaves.
  logic [WCW-1:0] r_word_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      r_word_cnt <= '0;
    else if (w_out_xfer)
      r_word_cnt <= (r_word_cnt == LAST_WORD) ? '0 : r_word_cnt + 1'b1;
  end

  // Derived from the held index, so it is stable while the word stalls and
  // low whenever no word is presented (including during reset).
  assign m_axis_output_tlast = r_out_vld & (r_word_cnt == LAST_WORD);
`endif

endmodule

// File: tb/tb_axis_elem_packer.sv
module tb_axis_elem_packer;

  localparam int EW = 8;
  localparam int PE = 4;
  localparam int BD = 3;

  logic          ap_clk;
  logic          ap_rst_n;
  logic [EW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  int total = 0;
  int bad   = 0;

  axis_elem_packer #(.ELEM_WIDTH(EW), .PE(PE), .BDIM(BD)) dut (
    .ap_clk              (ap_clk),
    .ap_rst_n            (ap_rst_n),
    .s_axis_input_tdata  (s_tdata),
    .s_axis_input_tvalid (s_tvalid),
    .s_axis_input_tready (s_tready),
    .m_axis_output_tdata (m_tdata),
    .m_axis_output_tvalid(m_tvalid),
    .m_axis_output_tready(m_tready)
`ifdef PACKER_TLAST_EN
    ,
    .m_axis_output_tlast (m_tlast)
`endif
  );

`ifndef PACKER_TLAST_EN
  assign m_tlast = 1'b0;
`endif

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_last(input string name, input logic exp);
`ifdef PACKER_TLAST_EN
    chk(name, 64'(m_tlast), 64'(exp));
`endif
  endtask

  // Apply inputs just after a rising edge, return at the falling edge where
  // the outputs for this cycle are sampled.
  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(posedge ap_clk);
    #1;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    @(negedge ap_clk);
  endtask

  // Continuous stream of nw words with output always ready; elements are
  // base, base+1, ...; block index of the first word must be 0.
  task automatic stream(input string tag, input int nw, input logic [7:0] base);
    int got = 0;
    logic [31:0] exp;
    for (int i = 0; i < 4 * nw + 2; i++) begin
      drive(i < 4 * nw, base + 8'(i), 1'b1);
      chk({tag, "_ir"}, 64'(s_tready), 64'd1);
      if (m_tvalid) begin
        for (int k = 0; k < 4; k++) exp[k*8 +: 8] = base + 8'(4 * got + k);
        chk({tag, "_data"}, 64'(m_tdata), 64'(exp));
        chk({tag, "_gap"}, 64'(i), 64'(4 * got + 4));
        chk_last({tag, "_last"}, (got % BD) == BD - 1);
        got++;
      end
    end
    chk({tag, "_words"}, 64'(got), 64'(nw));
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        e_ir;
    logic        e_ov;
    logic        chk_d;
    logic [31:0] e_od;
    logic        e_last;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // Single word, then a stall that backs up into the input, then a
    // drain and completion in the same cycle.
    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211, 1'b0};
    tbl[5]  = '{1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 1'b0};
    tbl[11] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 1'b0};
    tbl[12] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 1'b0};
    tbl[13] = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h88776655, 1'b0};
    tbl[14] = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h88776655, 1'b0};
    tbl[15] = '{1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 32'h88776655, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCCBBAA99, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 32'hCCBBAA99, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};

    ap_rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_ir", 64'(s_tready), 64'd0);
    chk("rst_ov", 64'(m_tvalid), 64'd0);
    chk("rst_od", 64'(m_tdata), 64'd0);
    chk_last("rst_last", 1'b0);
    ap_rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_ir", i), 64'(s_tready), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_ov", i), 64'(m_tvalid), 64'(tbl[i].e_ov));
      if (tbl[i].chk_d)
        chk($sformatf("tbl%0d_od", i), 64'(m_tdata), 64'(tbl[i].e_od));
      chk_last($sformatf("tbl%0d_last", i), tbl[i].e_last);
    end

    // 64 back-to-back elements: one word every 4 cycles, never stalls.
    stream("thru", 16, 8'h00);

    // Reset while a word is pending and a partial word is held.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h5A, 1'b0);
    drive(1'b1, 8'h5B, 1'b0);
    drive(1'b1, 8'h5B, 1'b0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    s_tvalid = 1'b0;
    @(negedge ap_clk);
    chk("mrst_ir", 64'(s_tready), 64'd0);
    chk("mrst_ov", 64'(m_tvalid), 64'd0);
    chk("mrst_od", 64'(m_tdata), 64'd0);
    chk_last("mrst_last", 1'b0);
    ap_rst_n = 1'b1;
    stream("post_rst", 3, 8'hA1);

    // Random handshakes against a reference model.
    begin
      int acc = 0;
      int cyc = 0;
      int mcnt = 0;
      int midx = 0;
      logic movld = 1'b0;
      logic [31:0] mdata = '0;
      logic [7:0] part[3];
      logic v, r, eir;
      logic [7:0] d;
      while (acc < 10000 && cyc < 60000) begin
        v = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        drive(v, d, r);
        cyc++;
        eir = !(mcnt == 3 && movld && !r);
        chk("rnd_ir", 64'(s_tready), 64'(eir));
        chk("rnd_ov", 64'(m_tvalid), 64'(movld));
        if (movld) begin
          chk("rnd_od", 64'(m_tdata), 64'(mdata));
          chk_last("rnd_last", (midx % BD) == BD - 1);
        end
        if (movld && r) midx++;
        if (v && eir) begin
          acc++;
          if (mcnt == 3) begin
            mdata = {d, part[2], part[1], part[0]};
            movld = 1'b1;
            mcnt  = 0;
          end else begin
            part[mcnt] = d;
            mcnt++;
            if (movld && r) movld = 1'b0;
          end
        end else if (movld && r) begin
          movld = 1'b0;
        end
      end
      chk("rnd_done", 64'(acc), 64'd10000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_elem_packer.md
AXIS_ELEM_PACKER -- requirements
Module: axis_elem_packer

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 8: bits per input element.
REQ-002 SHALL have parameter PE, default 4: elements packed per output word, legal range 2..64.
REQ-003 SHALL have parameter BDIM, default 16: output words per block, legal range 1..65535.
REQ-004 SHALL have port ap_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port ap_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port s_axis_input_tdata  input  ELEM_WIDTH  input element.
REQ-007 SHALL have port s_axis_input_tvalid  input  1  input element valid.
REQ-008 SHALL have port s_axis_input_tready  output  1  packer accepts an element this cycle.
REQ-009 SHALL have port m_axis_output_tdata  output  PE*ELEM_WIDTH  packed word.
REQ-010 SHALL have port m_axis_output_tvalid  output  1  packed word valid.
REQ-011 SHALL have port m_axis_output_tready  input  1  downstream accepts the word.
REQ-012 SHALL have port m_axis_output_tlast  output  1  last word of block; present only with PACKER_TLAST_EN.

Function
REQ-013 SHALL treat a transfer as occurring on a cycle where tvalid and tready are both 1 on the same interface.
REQ-014 SHALL place the k-th accepted element of a word (k = 0..PE-1) in tdata bits [k*ELEM_WIDTH +: ELEM_WIDTH], so element 0 occupies the LSBs.
REQ-015 SHALL hold a fill counter elem_cnt (0..PE-1) and a PE-element assembly register; each input transfer writes slot elem_cnt and increments elem_cnt.
REQ-016 SHALL, on the input transfer with elem_cnt = PE-1, move the completed word to the output register, set m_axis_output_tvalid the next cycle, and wrap elem_cnt to 0.
REQ-017 SHALL have a latency of exactly 1 cycle from the PE-th element transfer to m_axis_output_tvalid = 1.
REQ-018 SHALL keep m_axis_output_tdata, and tlast when present, stable while tvalid = 1 and tready = 0, and SHALL NOT drop tvalid before the transfer completes.
REQ-019 SHALL drive s_axis_input_tready = 0 only when elem_cnt = PE-1, m_axis_output_tvalid = 1 and m_axis_output_tready = 0; otherwise tready = 1.
REQ-020 SHALL, when the output register is drained and a new word completes in the same cycle, load the new word with tvalid staying 1, giving sustained throughput of 1 element/cycle and 1 word per PE cycles.
REQ-021 SHALL clear m_axis_output_tvalid the cycle after an output transfer when no new word completed in that cycle.
REQ-022 SHALL ignore s_axis_input_tdata whenever no input transfer occurs.
REQ-023 SHALL not expose partially assembled words; a partial word persists indefinitely across input idle cycles.

Reset
REQ-024 SHALL, while ap_rst_n = 0, asynchronously force elem_cnt = 0, word_cnt = 0, m_axis_output_tvalid = 0, m_axis_output_tlast = 0, and m_axis_output_tdata = 0.
REQ-025 SHALL drive s_axis_input_tready = 0 while ap_rst_n = 0 and SHALL drive it to 1 in the first cycle after release.
REQ-026 SHALL discard any partial word and any pending output word when reset asserts mid-operation; the first word after release is built from fresh elements only.

Configuration
REQ-027 SHALL use macro PACKER_TLAST_EN to select block framing.
REQ-028 SHALL, with PACKER_TLAST_EN defined, keep a word counter word_cnt (0..BDIM-1) that increments on each output transfer and wraps to 0 after BDIM-1, and SHALL assert m_axis_output_tlast with the word whose index is BDIM-1 (BDIM = 1: every word).
REQ-029 SHALL, without PACKER_TLAST_EN, omit the m_axis_output_tlast port and word_cnt entirely, with all other behaviour identical.

Verification
REQ-030 SHALL pass: PE=4, ELEM_WIDTH=8, elements 0x11,0x22,0x33,0x44 on consecutive cycles, tready=1 -> one cycle later tdata = 0x44332211 and tvalid = 1 for exactly one cycle.
REQ-031 SHALL pass: 64 elements streamed continuously, output tready=1 -> s_axis_input_tready never 0 and 16 words emitted at one word per 4 cycles.
REQ-032 SHALL pass: output tready held 0 for 10 cycles after the first word -> input stalls with elem_cnt = 3 after three more elements, tdata stable, and no data lost or duplicated after release.
REQ-033 SHALL pass with PACKER_TLAST_EN, BDIM=3: 9 words emitted -> tlast = 1 on words 2, 5 and 8 only.
REQ-034 SHALL pass: reset pulsed after 2 elements of a word, then 0xA1..0xA4 sent -> the first output word is 0xA4A3A2A1 and tlast (if enabled) follows a word_cnt restarted at 0.
REQ-035 SHALL pass: random tvalid/tready with 50% duty over 10,000 elements -> output equals the reference packing of the input sequence, with no handshake-rule violations.
